add16: RTL and testbench

ADD16 -- requirements
Module: add16

---
 rtl/add16.sv | 73 +++++++
 tb/tb_add16.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/add16.sv
// 16-bit ripple-carry adder; registered sum, carry and signed-overflow flags (flags built only with ADD16_FLAGS_EN).
// Latency 1 cycle; no backpressure, accepts one operand pair every cycle.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out,
    output logic        out_valid,
    output logic        cout,
    output logic        ovf
);
    logic [16:0] carry;
    logic [15:0] sum;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 16; i++) begin : g_cell
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= 16'h0000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= sum;
            end
        end
    end

`ifdef ADD16_FLAGS_EN
    logic ovf_next;

    // Signed overflow: same-sign operands whose sum flips sign.
    assign ovf_next = (a[15] == b[15]) && (sum[15] != a[15]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            cout <= carry[16];
            ovf  <= ovf_next;
        end
    end
`else
    assign cout = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_add16.sv
// Self-checking bench for add16: directed cases, reset behaviour and randomized traffic against an arithmetic model.

module tb_add16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic [15:0] out;
    logic        out_valid;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_out = 16'h0000;
    logic        exp_valid = 1'b0;
    logic        exp_cout = 1'b0;
    logic        exp_ovf = 1'b0;

    add16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, out, exp_out);
        check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, exp_valid});
        check({tag, ".cout"}, {15'd0, cout}, {15'd0, exp_cout});
        check({tag, ".ovf"}, {15'd0, ovf}, {15'd0, exp_ovf});
    endtask

    // Reference: plain 17-bit arithmetic for sum/carry, sign rule for overflow.
    task automatic model(input logic v, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] full;
        full = {1'b0, x} + {1'b0, y};
        exp_valid = v;
        if (v) begin
            exp_out = full[15:0];
`ifdef ADD16_FLAGS_EN
            exp_cout = full[16];
            exp_ovf  = (x[15] == y[15]) && (full[15] != x[15]);
`else
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
`endif
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        in_valid = v;
        a = x;
        b = y;
        @(posedge clk);
        model(v, x, y);
        #1;
        check_all(tag);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        // Reset held: outputs stay zero through edges even with valid operands.
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        #2;
        check_all("reset_initial");
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held");

        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        step("idle_after_reset", 1'b0, 16'hAAAA, 16'h5555);

        step("sum_0_0", 1'b1, 16'h0000, 16'h0000);
        step("sum_0_1", 1'b1, 16'h0000, 16'h0001);
        step("sum_1_1", 1'b1, 16'h0001, 16'h0001);
        step("sum_5_3", 1'b1, 16'h0005, 16'h0003);
        step("sum_1234_5678", 1'b1, 16'h1234, 16'h5678);
        step("wrap_ffff_1", 1'b1, 16'hFFFF, 16'h0001);
        step("ovf_7fff_1", 1'b1, 16'h7FFF, 16'h0001);
        step("ovf_8000_8000", 1'b1, 16'h8000, 16'h8000);
        step("neg_ffff_ffff", 1'b1, 16'hFFFF, 16'hFFFF);

        step("hold_load", 1'b1, 16'h0005, 16'h0003);
        step("hold_idle", 1'b0, 16'hFFFF, 16'hFFFF);
        step("hold_idle2", 1'b0, 16'h7FFF, 16'h7FFF);

        // Operands changing between edges must not disturb the registered result.
        step("sample_load", 1'b1, 16'h0101, 16'h0202);
        a = 16'hFFFF;
        b = 16'h8001;
        #2;
        check_all("sample_between_edges");

        step("stream0", 1'b1, 16'h0010, 16'h0001);
        step("stream1", 1'b1, 16'h0020, 16'h0002);
        step("stream2", 1'b1, 16'h7FFF, 16'h7FFF);
        step("stream3", 1'b1, 16'hFFF0, 16'h0020);
        step("stream_end", 1'b0, 16'h0000, 16'h0000);

        // Asynchronous reset mid-cycle discards the pending result.
        step("pre_reset_load", 1'b1, 16'h7FFF, 16'h0001);
        in_valid = 1'b1;
        a = 16'h8000;
        b = 16'h8000;
        #2;
        rst_n = 1'b0;
        exp_out = 16'h0000;
        exp_valid = 1'b0;
        exp_cout = 1'b0;
        exp_ovf = 1'b0;
        #1;
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_mid_edge");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        step("post_reset_idle", 1'b0, 16'h1111, 16'h2222);
        step("first_capture", 1'b1, 16'h0F0F, 16'h00F1);

        for (int i = 0; i < 300; i++) begin
            step("random", ($urandom_range(0, 3) != 0), pick_operand(), pick_operand());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
